cpu_handshake_sender: RTL

CPU_HANDSHAKE_SENDER -- requirements
Module: cpu_handshake_sender

---
 rtl/sender_pkg.sv | 13 +
 rtl/cpu_handshake_sender_if.sv | 25 ++
 rtl/sender_fifo.sv | 47 ++++
 rtl/cpu_handshake_sender.sv | 89 ++++++++
 4 files changed

// File: rtl/sender_pkg.sv
// Shared types and constants for the CPU-to-peripheral handshake sender.
package sender_pkg;
    localparam int DATA_W      = 32;
    localparam int CNT_W       = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;
endpackage

// File: rtl/cpu_handshake_sender_if.sv
// CPU write port plus peripheral handshake and status, bundled for the sender.
interface cpu_handshake_sender_if;
    import sender_pkg::*;

    logic              wrEn;
    logic [DATA_W-1:0] wrData;
    logic              full;
    logic              empty;
    logic              ACK;
    logic              SEND;
    logic [DATA_W-1:0] outData;
    logic              busy;
    logic              timeoutErr;
    logic [CNT_W-1:0]  sentCount;

    modport master (
        output wrEn, wrData, ACK,
        input  full, empty, SEND, outData, busy, timeoutErr, sentCount
    );

    modport slave (
        input  wrEn, wrData, ACK,
        output full, empty, SEND, outData, busy, timeoutErr, sentCount
    );
endinterface

// File: rtl/sender_fifo.sv
// Circular word FIFO with combinational head; pushes while full are dropped.
module sender_fifo
    import sender_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Fullness is judged before any same-cycle pop, so a pop never frees room for a write.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cpu_handshake_sender.sv
// Drains queued CPU words to a peripheral with a SEND/ACK four-phase handshake.
module cpu_handshake_sender
    import sender_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    cpu_handshake_sender_if.slave  bus
);
    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  sent_cnt;
    logic              tmo_q;
    logic              pop;
    logic              tmo;
    logic              done;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;

    sender_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wrEn),
        .pop   (pop),
        .din   (bus.wrData),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ACK is checked before the timeout so a late ACK in the last REQ cycle still wins.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tmo     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = REQ;
            REQ: begin
                if (bus.ACK) begin
                    state_d = REL;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                    tmo     = 1'b1;
                end
            end
            REL: begin
                if (!bus.ACK) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // REQ is only entered from IDLE, so holding the counter at zero outside REQ clears it on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            sent_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (state_q == REQ) wait_cnt <= wait_cnt + 1'b1;
            else                wait_cnt <= '0;
            if (done) sent_cnt <= sent_cnt + 1'b1;
            tmo_q <= tmo;
        end
    end

    assign bus.SEND       = (state_q == REQ);
    assign bus.busy       = (state_q != IDLE);
    assign bus.timeoutErr = tmo_q;
    assign bus.sentCount  = sent_cnt;
    assign bus.full       = fifo_full;
    assign bus.empty      = fifo_empty;
    assign bus.outData    = fifo_empty ? '0 : head;
endmodule
